memory_access_controller: RTL and testbench

MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

---
 rtl/memory_access_controller.sv | 142 ++++++++++++++
 tb/tb_memory_access_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_controller.sv
// Burst memory access controller: accepts read/write burst commands and sequences
// single-word RAM accesses (address load, write strobe, read enable) beat by beat.
module memory_access_controller #(
   parameter int SIZE = 8
) (
   input  logic            clk,
   input  logic            reset,
   // command channel
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_write,
   input  logic [SIZE-1:0] cmd_addr,
   input  logic [3:0]      cmd_len,
   // write data channel
   input  logic            wdata_valid,
   output logic            wdata_ready,
   input  logic [SIZE-1:0] wdata,
   // read data channel
   output logic            rdata_valid,
   input  logic            rdata_ready,
   output logic [SIZE-1:0] rdata,
   output logic            done,
   // RAM side
   output logic [SIZE-1:0] mem_address,
   output logic            mem_set_address,
   output logic            mem_set,
   output logic            mem_enable,
   output logic [SIZE-1:0] mem_data_in,
   input  logic [SIZE-1:0] mem_data_out
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WRITE,
      READ,
      RESP
   } state_t;

   state_t          state;
   state_t          state_next;

   logic [SIZE-1:0] cur_addr;
   logic [3:0]      beat_cnt;
   logic [3:0]      len_q;
   logic            write_q;
   logic [SIZE-1:0] rdata_q;
   logic            done_q;

   logic            accept;
   logic            beat_done;
   logic            last_beat;

   assign accept    = cmd_valid && cmd_ready;
   assign beat_done = ((state == WRITE) && wdata_valid) ||
                      ((state == RESP)  && rdata_ready);
   assign last_beat = (beat_cnt == len_q);

   assign rdata = rdata_q;
   assign done  = done_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // cmd_ready is gated by reset so it only rises once reset has been released
   always_comb begin
      state_next      = state;
      cmd_ready       = 1'b0;
      wdata_ready     = 1'b0;
      rdata_valid     = 1'b0;
      mem_address     = '0;
      mem_set_address = 1'b0;
      mem_set         = 1'b0;
      mem_enable      = 1'b0;
      mem_data_in     = '0;
      case (state)
         IDLE: begin
            cmd_ready = !reset;
            if (cmd_valid && !reset) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            mem_address     = cur_addr;
            mem_set_address = 1'b1;
            state_next      = write_q ? WRITE : READ;
         end
         WRITE: begin
            wdata_ready = 1'b1;
            mem_data_in = wdata;
            mem_set     = wdata_valid;
            if (wdata_valid) begin
               state_next = last_beat ? IDLE : LOAD;
            end
         end
         READ: begin
            mem_enable = 1'b1;
            state_next = RESP;
         end
         RESP: begin
            rdata_valid = 1'b1;
            if (rdata_ready) begin
               state_next = last_beat ? IDLE : LOAD;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_addr <= '0;
         beat_cnt <= '0;
         len_q    <= '0;
         write_q  <= 1'b0;
         rdata_q  <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= beat_done && last_beat;
         if (accept) begin
            write_q  <= cmd_write;
            cur_addr <= cmd_addr;
            len_q    <= cmd_len;
            beat_cnt <= '0;
         end else if (beat_done && !last_beat) begin
            cur_addr <= cur_addr + 1'b1;
            beat_cnt <= beat_cnt + 1'b1;
         end
         if (state == READ) begin
            rdata_q <= mem_data_out;
         end
      end
   end

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench for memory_access_controller with a behavioural address-latched RAM.
module tb_memory_access_controller;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [3:0] cmd_len;
   logic       wdata_valid;
   logic       wdata_ready;
   logic [7:0] wdata;
   logic       rdata_valid;
   logic       rdata_ready;
   logic [7:0] rdata;
   logic       done;
   logic [7:0] mem_address;
   logic       mem_set_address;
   logic       mem_set;
   logic       mem_enable;
   logic [7:0] mem_data_in;
   logic [7:0] mem_data_out;

   int n_checks = 0;
   int n_fail   = 0;
   int set_cnt  = 0;
   int en_cnt   = 0;
   int sa_cnt   = 0;
   int done_cnt = 0;
   logic prev_sa = 1'b0;

   logic [7:0] ram [256];
   logic [7:0] ram_addr;

   always #5 clk = ~clk;

   memory_access_controller #(.SIZE(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_write       (cmd_write),
      .cmd_addr        (cmd_addr),
      .cmd_len         (cmd_len),
      .wdata_valid     (wdata_valid),
      .wdata_ready     (wdata_ready),
      .wdata           (wdata),
      .rdata_valid     (rdata_valid),
      .rdata_ready     (rdata_ready),
      .rdata           (rdata),
      .done            (done),
      .mem_address     (mem_address),
      .mem_set_address (mem_set_address),
      .mem_set         (mem_set),
      .mem_enable      (mem_enable),
      .mem_data_in     (mem_data_in),
      .mem_data_out    (mem_data_out)
   );

   // RAM model: address latched by mem_set_address, combinational read port
   always @(posedge clk) begin
      if (mem_set_address) ram_addr <= mem_address;
      if (mem_set) ram[ram_addr] <= mem_data_in;
   end
   assign mem_data_out = ram[ram_addr];

   // protocol monitor, sampled on the falling edge
   always @(negedge clk) begin
      if (!reset) begin
         n_checks++;
         assert (!(mem_set && mem_enable)) else begin
            n_fail++;
            $error("FAIL set_enable_overlap: observed 1 expected 0");
         end
         n_checks++;
         assert (!(cmd_ready && (wdata_ready || rdata_valid || mem_set_address || mem_set || mem_enable))) else begin
            n_fail++;
            $error("FAIL cmd_ready_not_idle: observed 1 expected 0");
         end
         n_checks++;
         assert (!(mem_set_address && prev_sa)) else begin
            n_fail++;
            $error("FAIL set_address_two_cycles: observed 1 expected 0");
         end
         prev_sa = mem_set_address;
         if (mem_set) set_cnt++;
         if (mem_enable) en_cnt++;
         if (mem_set_address) sa_cnt++;
         if (done) done_cnt++;
      end else begin
         prev_sa = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_counts();
      set_cnt  = 0;
      en_cnt   = 0;
      sa_cnt   = 0;
      done_cnt = 0;
   endtask

   task automatic do_write(input logic [7:0] addr, input logic [3:0] len, input logic [7:0] base);
      logic [7:0] a;
      logic [7:0] d;
      chk("wr_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = addr;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         a = addr + 8'(i);
         d = base + 8'(i);
         chk("wr_set_address", mem_set_address, 1);
         chk("wr_address", mem_address, a);
         wdata_valid = 1'b1;
         wdata       = d;
         tick();
         chk("wr_wdata_ready", wdata_ready, 1);
         chk("wr_mem_set", mem_set, 1);
         chk("wr_mem_data_in", mem_data_in, d);
         tick();
         wdata_valid = 1'b0;
      end
      chk("wr_done", done, 1);
      chk("wr_idle_ready", cmd_ready, 1);
   endtask

   task automatic do_read(input logic [7:0] addr, input logic [3:0] len, input logic [7:0] base);
      logic [7:0] a;
      chk("rd_cmd_ready", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = addr;
      cmd_len   = len;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         a = addr + 8'(i);
         chk("rd_set_address", mem_set_address, 1);
         chk("rd_address", mem_address, a);
         chk("rd_valid_early", rdata_valid, 0);
         tick();
         chk("rd_mem_enable", mem_enable, 1);
         chk("rd_valid_in_read", rdata_valid, 0);
         tick();
         chk("rd_rdata_valid", rdata_valid, 1);
         chk("rd_rdata", rdata, base + 8'(i));
         chk("rd_enable_in_resp", mem_enable, 0);
         rdata_ready = 1'b1;
         tick();
         rdata_ready = 1'b0;
      end
      chk("rd_done", done, 1);
   endtask

   initial begin
      reset       = 1'b1;
      cmd_valid   = 1'b0;
      cmd_write   = 1'b0;
      cmd_addr    = '0;
      cmd_len     = '0;
      wdata_valid = 1'b0;
      wdata       = '0;
      rdata_ready = 1'b0;
      #1;
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_done", done, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_strobes", {mem_set, mem_enable, mem_set_address, wdata_ready, rdata_valid}, 0);
      #22;
      reset = 1'b0;
      tick();
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("post_rst_done", done, 0);

      // single write then single read at 0x12
      clear_counts();
      do_write(8'h12, 4'd0, 8'hA5);
      do_read(8'h12, 4'd0, 8'hA5);
      tick();
      chk("single_done_cnt", done_cnt, 2);
      chk("single_set_cnt", set_cnt, 1);
      chk("single_en_cnt", en_cnt, 1);
      chk("single_done_cleared", done, 0);

      // 4-beat burst across the address wrap
      clear_counts();
      do_write(8'hFE, 4'd3, 8'h01);
      do_read(8'hFE, 4'd3, 8'h01);
      tick();
      chk("burst_done_cnt", done_cnt, 2);
      chk("burst_sa_cnt", sa_cnt, 8);
      chk("burst_set_cnt", set_cnt, 4);
      chk("burst_en_cnt", en_cnt, 4);

      // read backpressure: rdata_ready held low for 5 cycles
      clear_counts();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'h12;
      cmd_len   = 4'd0;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("bp_rdata_valid", rdata_valid, 1);
         chk("bp_rdata", rdata, 8'hA5);
         chk("bp_no_enable", mem_enable, 0);
         tick();
      end
      chk("bp_rdata_valid_end", rdata_valid, 1);
      rdata_ready = 1'b1;
      tick();
      rdata_ready = 1'b0;
      chk("bp_done", done, 1);
      tick();
      chk("bp_en_cnt", en_cnt, 1);
      chk("bp_done_cnt", done_cnt, 1);

      // write stall: wdata_valid low 3 cycles in WRITE
      clear_counts();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_addr  = 8'h30;
      cmd_len   = 4'd0;
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk("stall_wdata_ready", wdata_ready, 1);
         chk("stall_no_set", mem_set, 0);
         tick();
      end
      wdata_valid = 1'b1;
      wdata       = 8'h5C;
      #1;
      chk("stall_set", mem_set, 1);
      chk("stall_data_in", mem_data_in, 8'h5C);
      tick();
      wdata_valid = 1'b0;
      chk("stall_done", done, 1);
      tick();
      chk("stall_set_cnt", set_cnt, 1);
      do_read(8'h30, 4'd0, 8'h5C);
      tick();

      // asynchronous reset in beat 2 of a 16-beat read
      clear_counts();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 8'hFE;
      cmd_len   = 4'd15;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("arst_beat1_rdata", rdata, 8'h01);
      rdata_ready = 1'b1;
      tick();
      rdata_ready = 1'b0;
      tick();
      chk("arst_beat2_enable", mem_enable, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_enable", mem_enable, 0);
      chk("arst_outputs", {cmd_ready, wdata_ready, rdata_valid, mem_set, mem_set_address, done}, 0);
      chk("arst_rdata", rdata, 0);
      chk("arst_address", mem_address, 0);
      tick();
      tick();
      reset = 1'b0;
      #1;
      chk("arst_release_ready", cmd_ready, 1);
      clear_counts();
      tick();
      tick();
      tick();
      chk("arst_no_strobes", sa_cnt + en_cnt + set_cnt, 0);
      chk("arst_no_done", done_cnt, 0);
      do_read(8'h12, 4'd0, 8'hA5);
      tick();
      chk("arst_after_done_cnt", done_cnt, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
